// File: rtl/ibex_fp_wb_arbiter_pkg.sv
// Shared types for the FP register-file writeback path.
// Requester encoding doubles as the round-robin priority value.
package ibex_fp_pkg;

    localparam int FP_REG_ADDR_W = 5;
    localparam int FP_NUM_REGS   = 1 << FP_REG_ADDR_W;

    typedef enum logic {
        FP_WB_FPU = 1'b0,
        FP_WB_LSU = 1'b1
    } fp_wb_src_e;

endpackage

// File: rtl/ibex_fp_wb_arbiter_if.sv
// Writeback requesters, issue-stage scoreboard access and W1 port.
// master drives requests/issue info, slave is the arbiter.
interface ibex_fp_wb_arbiter_if #(
    parameter int DataWidth = 16
);
    import ibex_fp_pkg::*;

    logic                     fpu_valid_i;
    logic                     fpu_ready_o;
    logic [FP_REG_ADDR_W-1:0] fpu_waddr_i;
    logic [DataWidth-1:0]     fpu_wdata_i;
    logic                     lsu_valid_i;
    logic                     lsu_ready_o;
    logic [FP_REG_ADDR_W-1:0] lsu_waddr_i;
    logic [DataWidth-1:0]     lsu_wdata_i;
    logic                     issue_valid_i;
    logic [FP_REG_ADDR_W-1:0] issue_rd_i;
    logic [FP_REG_ADDR_W-1:0] chk_rs1_i;
    logic [FP_REG_ADDR_W-1:0] chk_rs2_i;
    logic [FP_REG_ADDR_W-1:0] chk_rd_i;
    logic                     hazard_o;
    logic [FP_NUM_REGS-1:0]   busy_o;
    logic [FP_REG_ADDR_W-1:0] fp_waddr_o;
    logic [DataWidth-1:0]     fp_wdata_o;
    logic                     fp_we_o;
    logic                     err_o;

    modport master (
        output fpu_valid_i, fpu_waddr_i, fpu_wdata_i,
        output lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
        output issue_valid_i, issue_rd_i,
        output chk_rs1_i, chk_rs2_i, chk_rd_i,
        input  fpu_ready_o, lsu_ready_o,
        input  hazard_o, busy_o,
        input  fp_waddr_o, fp_wdata_o, fp_we_o, err_o
    );

    modport slave (
        input  fpu_valid_i, fpu_waddr_i, fpu_wdata_i,
        input  lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
        input  issue_valid_i, issue_rd_i,
        input  chk_rs1_i, chk_rs2_i, chk_rd_i,
        output fpu_ready_o, lsu_ready_o,
        output hazard_o, busy_o,
        output fp_waddr_o, fp_wdata_o, fp_we_o, err_o
    );

endinterface

// File: rtl/ibex_fp_wb_arbiter_scoreboard.sv
// Pending-write scoreboard for FP registers: set on issue,
// clear on register-file write, set wins on collision.
module ibex_fp_scoreboard
    import ibex_fp_pkg::*;
#(
    parameter bit WrenCheck = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     set_valid,
    input  logic [FP_REG_ADDR_W-1:0] set_addr,
    input  logic                     clr_valid,
    input  logic [FP_REG_ADDR_W-1:0] clr_addr,
    input  logic [FP_REG_ADDR_W-1:0] chk_a,
    input  logic [FP_REG_ADDR_W-1:0] chk_b,
    input  logic [FP_REG_ADDR_W-1:0] chk_c,
    output logic [FP_NUM_REGS-1:0]   busy,
    output logic                     hazard,
    output logic                     err
);

    logic [FP_NUM_REGS-1:0] busy_q;
    logic [FP_NUM_REGS-1:0] busy_d;
    logic                   set_en;
    logic                   clr_en;

    assign set_en = set_valid & (set_addr != '0);
    assign clr_en = clr_valid & (clr_addr != '0);

    always_comb begin
        busy_d = busy_q;
        if (clr_en) busy_d[clr_addr] = 1'b0;
        if (set_en) busy_d[set_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign busy   = busy_q;
    assign hazard = busy_q[chk_a] | busy_q[chk_b] | busy_q[chk_c];

    generate
        if (WrenCheck) begin : g_err
            logic err_q;
            logic err_d;
            logic same;

            assign same  = clr_en & (clr_addr == set_addr);
            assign err_d = (set_en & busy_q[set_addr] & ~same)
                         | (clr_en & ~busy_q[clr_addr]);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) err_q <= 1'b0;
                else        err_q <= err_d;
            end

            assign err = err_q;
        end else begin : g_no_err
            assign err = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/ibex_fp_wb_arbiter.sv
// FP register-file W1 arbiter between FPU and FP load results,
// with round-robin on contention and a registered write port.
module ibex_fp_wb_arbiter
    import ibex_fp_pkg::*;
#(
    parameter int DataWidth = 16,
    parameter bit WrenCheck = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    ibex_fp_wb_arbiter_if.slave bus
);

    fp_wb_src_e               prio_q;
    logic                     contested;
    logic                     grant_fpu;
    logic                     grant_lsu;
    logic [FP_REG_ADDR_W-1:0] gnt_addr;
    logic [DataWidth-1:0]     gnt_data;
    logic [FP_REG_ADDR_W-1:0] waddr_q;
    logic [DataWidth-1:0]     wdata_q;
    logic                     we_q;

    // A requester is only held off when the other one is valid and owns priority.
    assign contested       = bus.fpu_valid_i & bus.lsu_valid_i;
    assign bus.fpu_ready_o = ~(bus.lsu_valid_i & (prio_q == FP_WB_LSU));
    assign bus.lsu_ready_o = ~(bus.fpu_valid_i & (prio_q == FP_WB_FPU));

    assign grant_fpu = bus.fpu_valid_i & bus.fpu_ready_o;
    assign grant_lsu = bus.lsu_valid_i & bus.lsu_ready_o;
    assign gnt_addr  = grant_fpu ? bus.fpu_waddr_i : bus.lsu_waddr_i;
    assign gnt_data  = grant_fpu ? bus.fpu_wdata_i : bus.lsu_wdata_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q  <= FP_WB_FPU;
            waddr_q <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            we_q <= 1'b0;
            if (grant_fpu | grant_lsu) begin
                waddr_q <= gnt_addr;
                wdata_q <= gnt_data;
                we_q    <= (gnt_addr != '0);
            end
            if (contested) begin
                prio_q <= grant_fpu ? FP_WB_LSU : FP_WB_FPU;
            end
        end
    end

    assign bus.fp_waddr_o = waddr_q;
    assign bus.fp_wdata_o = wdata_q;
    assign bus.fp_we_o    = we_q;

    ibex_fp_scoreboard #(
        .WrenCheck (WrenCheck)
    ) u_scoreboard (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .set_valid (bus.issue_valid_i),
        .set_addr  (bus.issue_rd_i),
        .clr_valid (we_q),
        .clr_addr  (waddr_q),
        .chk_a     (bus.chk_rs1_i),
        .chk_b     (bus.chk_rs2_i),
        .chk_c     (bus.chk_rd_i),
        .busy      (bus.busy_o),
        .hazard    (bus.hazard_o),
        .err       (bus.err_o)
    );

endmodule

// File: tb/tb_ibex_fp_wb_arbiter.sv
// Bench for the FP writeback arbiter: directed scenarios plus
// random traffic against a pending-set / turn-based reference model.
module tb_ibex_fp_wb_arbiter;

    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ibex_fp_wb_arbiter_if #(.DataWidth(DW)) bus ();

    ibex_fp_wb_arbiter #(
        .DataWidth (DW),
        .WrenCheck (1'b1)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int tests = 0;
    int fails = 0;

    // Reference state: the set of pending registers, whose turn it is
    // on contention, and the write last handed to the register file.
    logic [31:0]   m_busy;
    bit            m_turn_lsu;
    bit            m_we;
    bit            m_err;
    bit            m_gf;
    bit            m_gl;
    logic [4:0]    m_waddr;
    logic [DW-1:0] m_wdata;

    task automatic model_reset();
        m_busy = '0; m_turn_lsu = 0; m_we = 0; m_err = 0;
        m_waddr = '0; m_wdata = '0; m_gf = 0; m_gl = 0;
    endtask

    task automatic model_edge();
        logic [31:0] nb;
        bit e;
        bit fv, lv, iv;
        logic [4:0] ird;
        fv  = bus.fpu_valid_i;
        lv  = bus.lsu_valid_i;
        iv  = bus.issue_valid_i;
        ird = bus.issue_rd_i;
        m_gf = fv && (!lv || !m_turn_lsu);
        m_gl = lv && !m_gf;
        if (fv && lv) m_turn_lsu = m_gf;
        e = 0;
        nb = m_busy;
        if (m_we) begin
            if (!m_busy[m_waddr]) e = 1;
            nb[m_waddr] = 1'b0;
        end
        if (iv && ird != 0) begin
            if (m_busy[ird] && !(m_we && m_waddr == ird)) e = 1;
            nb[ird] = 1'b1;
        end
        m_busy = nb;
        m_err  = e;
        m_we   = 0;
        if (m_gf || m_gl) begin
            m_waddr = m_gf ? bus.fpu_waddr_i : bus.lsu_waddr_i;
            m_wdata = m_gf ? bus.fpu_wdata_i : bus.lsu_wdata_i;
            m_we    = (m_waddr != 0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge();
        @(negedge clk);
    endtask

    task automatic drive(input bit fv, input logic [4:0] fa,
                         input logic [15:0] fd, input bit lv,
                         input logic [4:0] la, input logic [15:0] ld,
                         input bit iv, input logic [4:0] ird);
        bus.fpu_valid_i   = fv;
        bus.fpu_waddr_i   = fa;
        bus.fpu_wdata_i   = fd;
        bus.lsu_valid_i   = lv;
        bus.lsu_waddr_i   = la;
        bus.lsu_wdata_i   = ld;
        bus.issue_valid_i = iv;
        bus.issue_rd_i    = ird;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0, 1'b0, 5'd0);
    endtask

    task automatic set_chk(input logic [4:0] a, input logic [4:0] b,
                           input logic [4:0] c);
        bus.chk_rs1_i = a;
        bus.chk_rs2_i = b;
        bus.chk_rd_i  = c;
    endtask

    task automatic test_reset();
        tests++; if (bus.fp_we_o !== 1'b0) begin fails++; $display("FAIL reset_we: got %b want 0", bus.fp_we_o); end
        tests++; if (bus.fp_waddr_o !== 5'd0) begin fails++; $display("FAIL reset_waddr: got %0d want 0", bus.fp_waddr_o); end
        tests++; if (bus.fp_wdata_o !== 16'h0) begin fails++; $display("FAIL reset_wdata: got %h want 0", bus.fp_wdata_o); end
        tests++; if (bus.busy_o !== 32'h0) begin fails++; $display("FAIL reset_busy: got %h want 0", bus.busy_o); end
        tests++; if (bus.err_o !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", bus.err_o); end
        rst_n = 1'b1;
        drive(1'b1, 5'd10, 16'h1234, 1'b0, 5'd0, 16'h0, 1'b1, 5'd10);
        tick();
        idle();
        #2 rst_n = 1'b0;
        #1;
        tests++; if (bus.fp_we_o !== 1'b0) begin fails++; $display("FAIL midreset_we: got %b want 0", bus.fp_we_o); end
        tests++; if (bus.busy_o !== 32'h0) begin fails++; $display("FAIL midreset_busy: got %h want 0", bus.busy_o); end
        tests++; if (bus.fp_waddr_o !== 5'd0 || bus.fp_wdata_o !== 16'h0) begin fails++; $display("FAIL midreset_out: got %0d/%h want 0/0", bus.fp_waddr_o, bus.fp_wdata_o); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 5'd6, 16'h4200, 1'b0, 5'd0, 16'h0, 1'b0, 5'd0);
        tick();
        tests++; if (bus.fp_we_o !== 1'b1 || bus.fp_waddr_o !== 5'd6 || bus.fp_wdata_o !== 16'h4200) begin fails++; $display("FAIL post_reset_write: got we=%b %0d/%h want 1 6/4200", bus.fp_we_o, bus.fp_waddr_o, bus.fp_wdata_o); end
        idle();
        tick();
    endtask

    task automatic test_single();
        drive(1'b1, 5'd3, 16'h3C00, 1'b0, 5'd0, 16'h0, 1'b0, 5'd0);
        #1;
        tests++; if (bus.fpu_ready_o !== 1'b1) begin fails++; $display("FAIL single_ready: got %b want 1", bus.fpu_ready_o); end
        tick();
        tests++; if (bus.fp_we_o !== 1'b1 || bus.fp_waddr_o !== 5'd3 || bus.fp_wdata_o !== 16'h3C00) begin fails++; $display("FAIL single_write: got we=%b %0d/%h want 1 3/3c00", bus.fp_we_o, bus.fp_waddr_o, bus.fp_wdata_o); end
        idle();
        tick();
        tests++; if (bus.fp_we_o !== 1'b0 || bus.fp_waddr_o !== 5'd3) begin fails++; $display("FAIL single_hold: got we=%b addr=%0d want 0 3", bus.fp_we_o, bus.fp_waddr_o); end
    endtask

    task automatic test_contention();
        int nf = 0;
        int nl = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd1, 16'(16'hF000 + nf), 1'b1, 5'd2, 16'(16'hA000 + nl), 1'b0, 5'd0);
            #1;
            tests++; if (bus.fpu_ready_o !== (i % 2 == 0) || bus.lsu_ready_o !== (i % 2 == 1)) begin fails++; $display("FAIL contention_ready%0d: got f=%b l=%b want f=%b", i, bus.fpu_ready_o, bus.lsu_ready_o, (i % 2 == 0)); end
            tick();
            tests++; if (bus.fp_we_o !== 1'b1 || bus.fp_waddr_o !== ((i % 2 == 0) ? 5'd1 : 5'd2) || bus.fp_wdata_o !== ((i % 2 == 0) ? 16'(16'hF000 + i / 2) : 16'(16'hA000 + i / 2))) begin fails++; $display("FAIL contention_write%0d: got we=%b %0d/%h", i, bus.fp_we_o, bus.fp_waddr_o, bus.fp_wdata_o); end
            if (i % 2 == 0) nf++;
            else            nl++;
        end
        idle();
        tick();
    endtask

    task automatic test_scoreboard();
        idle();
        set_chk(5'd5, 5'd0, 5'd0);
        tick();
        tests++; if (bus.hazard_o !== 1'b0) begin fails++; $display("FAIL sb_idle_hazard: got %b want 0", bus.hazard_o); end
        drive(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0, 1'b1, 5'd5);
        tick();
        tests++; if (bus.busy_o[5] !== 1'b1 || bus.hazard_o !== 1'b1) begin fails++; $display("FAIL sb_set: got busy5=%b hazard=%b want 1 1", bus.busy_o[5], bus.hazard_o); end
        idle();
        tick();
        drive(1'b0, 5'd0, 16'h0, 1'b1, 5'd5, 16'h1111, 1'b0, 5'd0);
        #1;
        tests++; if (bus.lsu_ready_o !== 1'b1) begin fails++; $display("FAIL sb_lsu_ready: got %b want 1", bus.lsu_ready_o); end
        tick();
        tests++; if (bus.fp_we_o !== 1'b1 || bus.busy_o[5] !== 1'b1) begin fails++; $display("FAIL sb_write: got we=%b busy5=%b want 1 1", bus.fp_we_o, bus.busy_o[5]); end
        idle();
        tick();
        tests++; if (bus.busy_o[5] !== 1'b0 || bus.hazard_o !== 1'b0 || bus.err_o !== 1'b0) begin fails++; $display("FAIL sb_clear: got busy5=%b hazard=%b err=%b want 0 0 0", bus.busy_o[5], bus.hazard_o, bus.err_o); end
        set_chk(5'd0, 5'd0, 5'd0);
    endtask

    task automatic test_simultaneous();
        drive(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0, 1'b1, 5'd7);
        tick();
        drive(1'b0, 5'd0, 16'h0, 1'b1, 5'd7, 16'h7777, 1'b0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0, 1'b1, 5'd7);
        tick();
        tests++; if (bus.busy_o[7] !== 1'b1 || bus.err_o !== 1'b0) begin fails++; $display("FAIL simul_set_clear: got busy7=%b err=%b want 1 0", bus.busy_o[7], bus.err_o); end
        drive(1'b0, 5'd0, 16'h0, 1'b1, 5'd7, 16'h7778, 1'b0, 5'd0);
        tick();
        idle();
        tick();
        tests++; if (bus.busy_o[7] !== 1'b0) begin fails++; $display("FAIL simul_final: got busy7=%b want 0", bus.busy_o[7]); end
    endtask

    task automatic test_x0_err();
        idle();
        tick();
        drive(1'b1, 5'd0, 16'hDEAD, 1'b0, 5'd0, 16'h0, 1'b0, 5'd0);
        #1;
        tests++; if (bus.fpu_ready_o !== 1'b1) begin fails++; $display("FAIL x0_ready: got %b want 1", bus.fpu_ready_o); end
        tick();
        tests++; if (bus.fp_we_o !== 1'b0) begin fails++; $display("FAIL x0_we: got %b want 0", bus.fp_we_o); end
        drive(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0, 1'b1, 5'd9);
        tick();
        tests++; if (bus.err_o !== 1'b0) begin fails++; $display("FAIL err_first_issue: got %b want 0", bus.err_o); end
        tick();
        tests++; if (bus.err_o !== 1'b1) begin fails++; $display("FAIL err_double_issue: got %b want 1", bus.err_o); end
        idle();
        tick();
        tests++; if (bus.err_o !== 1'b0) begin fails++; $display("FAIL err_pulse_len: got %b want 0", bus.err_o); end
        drive(1'b1, 5'd4, 16'h4444, 1'b0, 5'd0, 16'h0, 1'b0, 5'd0);
        tick();
        idle();
        tick();
        tests++; if (bus.err_o !== 1'b1) begin fails++; $display("FAIL err_clear_idle: got %b want 1", bus.err_o); end
        drive(1'b1, 5'd9, 16'h9999, 1'b0, 5'd0, 16'h0, 1'b0, 5'd0);
        tick();
        idle();
        tick();
        tick();
        tests++; if (bus.busy_o !== 32'h0) begin fails++; $display("FAIL err_cleanup: got %h want 0", bus.busy_o); end
    endtask

    task automatic test_random();
        bit fp = 0;
        bit lp = 0;
        logic [4:0]  fa = '0;
        logic [4:0]  la = '0;
        logic [15:0] fd = '0;
        logic [15:0] ld = '0;
        logic [4:0]  r1, r2, r3;
        bit exp_gf, exp_gl;
        for (int c = 0; c < 600; c++) begin
            if (!fp && $urandom_range(1, 0) == 1) begin
                fp = 1; fa = 5'($urandom); fd = 16'($urandom);
            end
            if (!lp && $urandom_range(1, 0) == 1) begin
                lp = 1; la = 5'($urandom); ld = 16'($urandom);
            end
            r1 = 5'($urandom); r2 = 5'($urandom); r3 = 5'($urandom);
            drive(fp, fa, fd, lp, la, ld, $urandom_range(2, 0) == 0, 5'($urandom));
            set_chk(r1, r2, r3);
            #1;
            exp_gf = fp && (!lp || !m_turn_lsu);
            exp_gl = lp && !exp_gf;
            tests++; if ((fp && bus.fpu_ready_o) !== exp_gf || (lp && bus.lsu_ready_o) !== exp_gl) begin fails++; $display("FAIL rand_grant c=%0d: got f=%b l=%b want f=%b l=%b", c, fp && bus.fpu_ready_o, lp && bus.lsu_ready_o, exp_gf, exp_gl); end
            tests++; if (bus.hazard_o !== (m_busy[r1] | m_busy[r2] | m_busy[r3])) begin fails++; $display("FAIL rand_hazard c=%0d: got %b want %b", c, bus.hazard_o, m_busy[r1] | m_busy[r2] | m_busy[r3]); end
            tick();
            tests++; if (bus.fp_we_o !== m_we || bus.busy_o !== m_busy || bus.err_o !== m_err) begin fails++; $display("FAIL rand_state c=%0d: got we=%b busy=%h err=%b want we=%b busy=%h err=%b", c, bus.fp_we_o, bus.busy_o, bus.err_o, m_we, m_busy, m_err); end
            if (m_we) begin
                tests++; if (bus.fp_waddr_o !== m_waddr || bus.fp_wdata_o !== m_wdata) begin fails++; $display("FAIL rand_write c=%0d: got %0d/%h want %0d/%h", c, bus.fp_waddr_o, bus.fp_wdata_o, m_waddr, m_wdata); end
            end
            if (m_gf) fp = 0;
            if (m_gl) lp = 0;
        end
        idle();
        tick();
    endtask

    initial begin
        model_reset();
        idle();
        set_chk(5'd0, 5'd0, 5'd0);
        @(negedge clk);
        @(negedge clk);
        test_reset();
        test_single();
        test_contention();
        test_scoreboard();
        test_simultaneous();
        test_x0_err();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
